// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: values shared by the program loader and the core's
// instruction-memory models.
//   - MEMORY_DEPTH_DEF / ADDR_WIDTH_DEF : instruction memory geometry (bytes)
//   - SYNC_BYTE_DEF                     : frame start marker
//   - ST_*                              : loader FSM state encodings
package prog_loader_pkg;

  localparam int unsigned MEMORY_DEPTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF   = 5;
  localparam logic [7:0]  SYNC_BYTE_DEF    = 8'hA5;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CHK  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and instruction-memory write bus of the
// program loader.
//   rx_valid, rx_data  : byte source -> loader
//   rx_ready           : loader -> byte source
//   mem_we, mem_addr, mem_wdata : loader -> instruction memory
// Modports: master = loader side, slave = source/memory side.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/prog_loader.sv
// prog_loader: parses a framed byte stream (SYNC, N, N payload bytes,
// optional checksum) and writes the payload into byte-wide instruction
// memory from address 0, holding the core in reset until a valid image is in.
//
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : prog_loader_if.master (rx byte handshake + memory write port)
//   core_rst : reset to the core, high unless a valid image is loaded
//   done     : valid image loaded, core running
//   error    : last frame rejected
//
// Build option: define PROG_LOADER_CHECKSUM_EN to add the trailing checksum
// byte (8-bit wrapping sum of the payload) and its CHK state.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | hunting for SYNC_BYTE, other bytes dropped
// LEN   | next byte is payload length N (1..MEMORY_DEPTH)
// DATA  | writing payload bytes, down-counting remaining bytes
// CHK   | next byte is the payload checksum (checksum build only)
// DONE  | image valid, core released; SYNC_BYTE restarts a load
// ERR   | frame rejected, core held; SYNC_BYTE restarts a load
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH = MEMORY_DEPTH_DEF,
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  prog_loader_if.master     bus,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  logic [2:0]            state_q, state_d;
  logic                  rx_ready_q;
  logic [7:0]            rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  core_rst_q, done_q, error_q;
  logic                  xfer;
  logic                  is_sync;
  logic                  len_bad;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  assign xfer    = bus.rx_valid && rx_ready_q;
  assign is_sync = (bus.rx_data == SYNC_BYTE);
  assign len_bad = (bus.rx_data == 8'd0) || (32'(bus.rx_data) > MEMORY_DEPTH);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    addr_d      = addr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (xfer && is_sync) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (xfer) begin
          if (len_bad) begin
            state_d = ST_ERR;
          end else begin
            rem_d   = bus.rx_data;
            addr_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_d  = 8'd0;
`endif
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = bus.rx_data;
          addr_d      = addr_q + ADDR_WIDTH'(1);
          rem_d       = rem_q - 8'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d      = csum_q + bus.rx_data;
          if (rem_q == 8'd1) state_d = ST_CHK;
`else
          if (rem_q == 8'd1) state_d = ST_DONE;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (xfer) state_d = (bus.rx_data == csum_q) ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE, ST_ERR: begin
        if (xfer && is_sync) state_d = ST_LEN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rx_ready_q  <= 1'b0;
      rem_q       <= 8'd0;
      addr_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= 1'b1;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      // Decoded from the next state so the core leaves reset on the same
      // edge that captures the final write.
      core_rst_q  <= (state_d != ST_DONE);
      done_q      <= (state_d == ST_DONE);
      error_q     <= (state_d == ST_ERR);
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign core_rst      = core_rst_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: directed byte frames; expected memory writes are
// queued as bytes are sent and checked by an independent write monitor.
module tb_prog_loader;
  import prog_loader_pkg::*;

  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_rst, done, error;

  int n_chk  = 0;
  int n_fail = 0;

  wr_t        exp_q[$];
  logic [7:0] mem_model [32];

  prog_loader_if #(.ADDR_WIDTH(5)) bus ();

  prog_loader #(
    .MEMORY_DEPTH(32),
    .ADDR_WIDTH  (5),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .core_rst(core_rst),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_status(input string name, input logic cr, input logic dn, input logic er);
    chk({name, ".core_rst"}, 32'(core_rst), 32'(cr));
    chk({name, ".done"},     32'(done),     32'(dn));
    chk({name, ".error"},    32'(error),    32'(er));
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic exp_wr(input int a, input logic [7:0] d);
    wr_t w;
    w.a = 5'(a);
    w.d = d;
    exp_q.push_back(w);
  endtask

  // Valid frame: SYNC, N, payload, checksum byte (ignored in DONE when the
  // checksum build option is off).
  task automatic frame(input logic [7:0] pay[$], input logic [7:0] cs);
    send(8'hA5);
    send(8'(pay.size()));
    foreach (pay[i]) begin
      exp_wr(i, pay[i]);
      send(pay[i]);
    end
    send(cs);
  endtask

  // Write monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && bus.mem_we) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.mem_addr),  32'(e.a));
        chk("wr_data", 32'(bus.mem_wdata), 32'(e.d));
      end
      mem_model[bus.mem_addr] = bus.mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pl[$];
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    foreach (mem_model[i]) mem_model[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rx_ready",  32'(bus.rx_ready),  32'd0);
    chk("rst.mem_we",    32'(bus.mem_we),    32'd0);
    chk("rst.mem_addr",  32'(bus.mem_addr),  32'd0);
    chk("rst.mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk_status("rst", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel.rx_ready", 32'(bus.rx_ready), 32'd1);

    // Garbage before sync is dropped; single-byte image
    send(8'h00);
    send(8'hFF);
    chk_status("idle_garbage", 1'b1, 1'b0, 1'b0);
    pl = {8'h7E};
    frame(pl, 8'h7E);
    chk_status("one_byte", 1'b0, 1'b1, 1'b0);

    // Four-byte image, core_rst falls on the final byte edge
    send(8'hA5);
    chk_status("restart_sync", 1'b1, 1'b0, 1'b0);
    send(8'h04);
    exp_wr(0, 8'h13); send(8'h13);
    exp_wr(1, 8'h00); send(8'h00);
    exp_wr(2, 8'h00); send(8'h00);
    exp_wr(3, 8'h00); send(8'h00);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk_status("four_last_payload", 1'b1, 1'b0, 1'b0);
`else
    chk_status("four_last_payload", 1'b0, 1'b1, 1'b0);
`endif
    send(8'h13);
    chk_status("four_done", 1'b0, 1'b1, 1'b0);

    // Bad lengths
    send(8'hA5);
    send(8'h00);
    chk_status("len_zero", 1'b1, 1'b0, 1'b1);
    send(8'h17);
    chk_status("err_ignores", 1'b1, 1'b0, 1'b1);
    send(8'hA5);
    send(8'h21);
    chk_status("len_33", 1'b1, 1'b0, 1'b1);
    pl = {8'h55};
    frame(pl, 8'h55);
    chk_status("recover", 1'b0, 1'b1, 1'b0);

    // Full-depth image: bytes 0..31, sum 496 mod 256 = F0
    pl = {};
    for (int i = 0; i < 32; i++) pl.push_back(8'(i));
    frame(pl, 8'hF0);
    chk_status("len_32", 1'b0, 1'b1, 1'b0);

    // Sync value inside payload is data: A5+A5 = 14A -> 4A
    pl = {8'hA5, 8'hA5};
    frame(pl, 8'h4A);
    chk_status("sync_in_data", 1'b0, 1'b1, 1'b0);

    // Reload from DONE
    send(8'hA5);
    chk_status("done_resync", 1'b1, 1'b0, 1'b0);
    send(8'h01);
    exp_wr(0, 8'h22); send(8'h22);
    send(8'h22);
    chk_status("done_reload", 1'b0, 1'b1, 1'b0);

    // Bad checksum: 10+20 = 30, send 31
    pl = {8'h10, 8'h20};
    frame(pl, 8'h31);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk_status("bad_csum", 1'b1, 1'b0, 1'b1);
`else
    chk_status("bad_csum", 1'b0, 1'b1, 1'b0);
`endif
    pl = {8'h10, 8'h20};
    frame(pl, 8'h30);
    chk_status("good_csum", 1'b0, 1'b1, 1'b0);

    // Reset mid-frame leaves the partial image
    send(8'hA5);
    send(8'h03);
    exp_wr(0, 8'hAA); send(8'hAA);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst.rx_ready", 32'(bus.rx_ready), 32'd0);
    chk_status("midrst", 1'b1, 1'b0, 1'b0);
    chk("midrst.mem0", 32'(mem_model[0]), 32'hAA);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    pl = {8'h5A, 8'h3C};
    frame(pl, 8'h96);
    chk_status("after_rst", 1'b0, 1'b1, 1'b0);
    chk("after_rst.mem1", 32'(mem_model[1]), 32'h3C);
    chk("keep_beyond_n", 32'(mem_model[5]), 32'h05);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
